image_loader: RTL
=================

Name: image_loader

Overview:
- Front-end writer for the network's input/output RAM.
- Accepts a 784-pixel image on a valid/ready byte stream and converts each 8-bit pixel to 16-bit fixed point.
- Writes each converted pixel into the INPUT region, pulses Compute, waits for the network's R handshake, then runs a sequential signed argmax over the 10 output probabilities.
- Sits between the host/UART pixel source and neural_network. Owns the RAM write port while Busy=1; the top level muxes the port on Busy.

Parameters:
- NUM_PIXELS, 784, pixels per image; index counter is 10 bits.
- NUM_CLASSES, 10, output probabilities scanned by argmax.
- FRAC_BITS, 12, fractional bits of the 16-bit fixed-point format; must be >= 8.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin loading a new image; sampled in IDLE or DONE only
- Pixel_Valid  in  1  pixel source has data
- Pixel_Data  in  8  unsigned pixel, 0..255
- Pixel_Ready  out  1  loader accepts a pixel this cycle
- Wren  out  1  RAM write enable (registered)
- Address  out  10  RAM address, INPUT + index (registered)
- D  out  16  RAM write data (registered)
- Compute  out  1  one-cycle start pulse to neural_network
- R  in  1  network result-ready level
- Probability  in  16 x NUM_CLASSES  signed fixed-point network outputs
- Busy  out  1  high in every state except IDLE and DONE
- Done  out  1  high in DONE; Class valid
- Class  out  4  argmax index

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; Wren=0, Address=0, D=0, Compute=0, Pixel_Ready=0, Busy=0, Done=0, Class=0; index=0.
- States: IDLE, LOAD, KICK, WAIT_LO, WAIT_HI, SCAN, DONE.
- IDLE/DONE:
  - Start=1 -> LOAD next cycle; index=0; Done falls.
  - DONE holds Class until Start.
- LOAD:
  - Pixel_Ready=1 (registered; asserted on the first LOAD cycle).
  - A handshake (Pixel_Valid & Pixel_Ready) at cycle t produces Wren=1, Address=INPUT+index, D=Pixel_Data<<(FRAC_BITS-8) zero-extended, all at cycle t+1; index then increments.
  - Wren=0 in cycles with no handshake.
  - After the handshake with index=NUM_PIXELS-1 -> KICK; Pixel_Ready=0 from the next cycle. The final write still issues at t+1.
  - No more than NUM_PIXELS pixels are ever accepted per image.
- KICK: Compute=1 for exactly one cycle -> WAIT_LO.
- WAIT_LO: wait for R=0 (network busy) -> WAIT_HI. This guards against a stale R left high from the previous image.
- WAIT_HI: wait for R=1 -> SCAN; capture the Probability vector into a local register on entry.
- SCAN:
  - One class per cycle, indices 0..NUM_CLASSES-1, signed 16-bit compare.
  - Best is updated only on strictly greater, so ties resolve to the lowest index.
  - Takes NUM_CLASSES cycles, then -> DONE; Class=best index, Done=1.
- Start outside IDLE/DONE is ignored. Pixel_Valid outside LOAD is ignored; Pixel_Ready=0.
- Reset mid-operation aborts immediately. No partial write is completed: Wren=0 asynchronously.
- Latency:
  - Start to first Pixel_Ready: 1 cycle.
  - Last handshake to Compute pulse: 2 cycles.
  - R rise to Done: NUM_CLASSES+1 cycles.

Decomposition:
- Shared package BRAM_ADDRS (existing): INPUT base address, reused as-is.
- Add to shared constants: NUM_PIXELS, NUM_CLASSES, FRAC_BITS, and the loader state enum typedef, so the top level and testbench can decode state.
- One natural sub-module: argmax_seq. It captures a 16 x NUM_CLASSES vector on a start pulse, scans one class per cycle, and returns index plus a done pulse.
- Pixel path and FSM stay in image_loader.

Test Plan:
- Full load, Pixel_Valid=1 every cycle, Pixel_Data=index mod 256 -> 784 writes, Address INPUT..INPUT+783 contiguous, D at index 255 equals 0x0FF0; one Compute pulse exactly 2 cycles after the last accept.
- Bursty source, Pixel_Valid toggling 1-0-0 -> still exactly 784 writes with Wren only on handshake+1 cycles; a 785th pixel offered is never accepted (Pixel_Ready=0).
- Argmax: Probability = {0x0100 at idx3, 0x0100 at idx7, 0xF000 elsewhere}, R held high then low then high -> Class=3 (tie lowest), Done exactly 11 cycles after the R rise.
- All Probability negative with max at idx9 = 0xFFFF -> Class=9, confirming the signed compare.
- Stale R=1 during KICK -> no SCAN until R drops and rises again.
- Reset asserted at pixel 400 -> outputs immediately at reset values; a subsequent Start performs a clean full load from Address=INPUT.

Source files
------------

// File: rtl/image_loader_pkg.sv
// Shared constants, loader state encoding and the pixel-to-fixed-point helper
// used by the image loader, its argmax unit and anything that decodes loader state.
package image_loader_pkg;

   localparam int NUM_PIXELS  = 784;
   localparam int NUM_CLASSES = 10;
   localparam int FRAC_BITS   = 12;

   localparam int PIX_W   = 8;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 10;
   localparam int IDX_W   = 10;
   localparam int CLASS_W = 4;

   // Base of the INPUT region in the network's shared input/output RAM.
   localparam logic [ADDR_W-1:0] INPUT_ADDR = 10'd32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT_LO,
      S_WAIT_HI,
      S_SCAN,
      S_DONE
   } loader_state_t;

   function automatic logic [DATA_W-1:0] pixel_to_fixed(input logic [PIX_W-1:0] pix);
      return {{(DATA_W-PIX_W){1'b0}}, pix} << (FRAC_BITS - PIX_W);
   endfunction

endpackage

// File: rtl/image_loader_argmax.sv
// Sequential signed argmax: captures the probability vector on i_start, then
// compares one class per cycle and pulses o_done with the winning index.
module argmax_seq
   import image_loader_pkg::*;
(
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_start,
   input  logic [DATA_W*NUM_CLASSES-1:0]   i_vec,
   output logic                            o_done,
   output logic [CLASS_W-1:0]              o_index
);

   logic signed [DATA_W-1:0] r_vec [NUM_CLASSES];
   logic signed [DATA_W-1:0] r_best;
   logic [CLASS_W-1:0]       r_best_idx;
   logic [CLASS_W-1:0]       r_idx;
   logic [CLASS_W-1:0]       r_index;
   logic                     r_active;
   logic                     r_done;
   logic                     w_greater;

   // Strictly greater keeps the earliest index on ties.
   assign w_greater = r_vec[r_idx] > r_best;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_CLASSES; i++) r_vec[i] <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_idx      <= '0;
         r_index    <= '0;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_vec[i] <= i_vec[DATA_W*i +: DATA_W];
            r_best     <= i_vec[DATA_W-1:0];
            r_best_idx <= '0;
            r_idx      <= CLASS_W'(1);
            r_active   <= 1'b1;
         end else if (r_active) begin
            if (w_greater) begin
               r_best     <= r_vec[r_idx];
               r_best_idx <= r_idx;
            end
            if (r_idx == CLASS_W'(NUM_CLASSES-1)) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
               r_index  <= w_greater ? r_idx : r_best_idx;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign o_done  = r_done;
   assign o_index = r_index;

endmodule

// File: rtl/image_loader.sv
// Loads one image into the network's INPUT region, kicks the network, waits for a
// fresh result and reports the argmax class. Owns the RAM write port while busy.
module image_loader
   import image_loader_pkg::*;
(
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_start,
   input  logic                            i_pixel_valid,
   input  logic [PIX_W-1:0]                i_pixel_data,
   output logic                            o_pixel_ready,
   output logic                            o_wren,
   output logic [ADDR_W-1:0]               o_address,
   output logic [DATA_W-1:0]               o_d,
   output logic                            o_compute,
   input  logic                            i_r,
   input  logic [DATA_W*NUM_CLASSES-1:0]   i_probability,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [CLASS_W-1:0]              o_class,
   output loader_state_t                   o_state
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS-1);

   // Handshake: a pixel moves when i_pixel_valid and o_pixel_ready are both high
   // at a rising edge; o_pixel_ready is only ever high in LOAD.
   loader_state_t       r_state;
   logic [IDX_W-1:0]    r_index;
   logic                r_pixel_ready;
   logic                r_wren;
   logic [ADDR_W-1:0]   r_address;
   logic [DATA_W-1:0]   r_d;
   logic                r_compute;
   logic                r_busy;
   logic                r_done;
   logic [CLASS_W-1:0]  r_class;

   logic                w_handshake;
   logic                w_scan_start;
   logic                w_argmax_done;
   logic [CLASS_W-1:0]  w_argmax_index;

   assign w_handshake  = i_pixel_valid & r_pixel_ready;
   assign w_scan_start = (r_state == S_WAIT_HI) & i_r;

   argmax_seq u_argmax (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_start (w_scan_start),
      .i_vec   (i_probability),
      .o_done  (w_argmax_done),
      .o_index (w_argmax_index)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_index       <= '0;
         r_pixel_ready <= 1'b0;
         r_wren        <= 1'b0;
         r_address     <= '0;
         r_d           <= '0;
         r_compute     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class       <= '0;
      end else begin
         r_wren    <= 1'b0;
         r_compute <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state       <= S_LOAD;
                  r_index       <= '0;
                  r_pixel_ready <= 1'b1;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_handshake) begin
                  r_wren    <= 1'b1;
                  r_address <= INPUT_ADDR + r_index;
                  r_d       <= pixel_to_fixed(i_pixel_data);
                  r_index   <= r_index + 1'b1;
                  if (r_index == IDX_LAST) begin
                     r_state       <= S_KICK;
                     r_pixel_ready <= 1'b0;
                  end
               end
            end
            S_KICK: begin
               r_compute <= 1'b1;
               r_state   <= S_WAIT_LO;
            end
            // R must be seen low first so a result left over from the last image is not reused.
            S_WAIT_LO: if (!i_r) r_state <= S_WAIT_HI;
            S_WAIT_HI: if (i_r)  r_state <= S_SCAN;
            S_SCAN: begin
               if (w_argmax_done) begin
                  r_state <= S_DONE;
                  r_class <= w_argmax_index;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_pixel_ready = r_pixel_ready;
   assign o_wren        = r_wren;
   assign o_address     = r_address;
   assign o_d           = r_d;
   assign o_compute     = r_compute;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_class       = r_class;
   assign o_state       = r_state;

endmodule
